// File: rtl/onehot_updown_counter.sv
// One-hot modulo-N up/down counter with clear, load,
// wrap pulse and one-hot integrity recovery.
module onehot_updown_counter #(
  parameter  int N = 6,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         clr,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  input  logic         c_up,
  input  logic         c_dn,
  output logic [N-1:0] st,
  output logic [W-1:0] cnt,
  output logic         zero,
  output logic         wrap,
  output logic         err
);

  logic [N-1:0] r_st;
  logic         r_wrap;
  logic         r_err;

  logic [N-1:0] w_nxt;
  logic [N-1:0] w_hot;
  logic [W-1:0] w_cnt;
  logic         w_any;
  logic         w_multi;
  logic         w_ill;
  logic         w_ok;
  logic         w_up;
  logic         w_dn;
  logic         w_hold;
  logic         w_cnt_en;
  logic         w_wrap;
  logic         w_err;

  always_comb begin
    w_any   = 1'b0;
    w_multi = 1'b0;
    for (int i = 0; i < N; i++) begin
      w_multi = w_multi | (w_any & r_st[i]);
      w_any   = w_any | r_st[i];
    end
  end

  always_comb begin
    w_cnt = '0;
    for (int i = 0; i < N; i++) begin
      if (r_st[i]) begin
        w_cnt = w_cnt | W'(i);
      end
    end
  end

  assign w_ill    = ~w_any | w_multi;
  assign w_ok     = |w_hot;
  assign w_up     = c_up & ~c_dn;
  assign w_dn     = c_dn & ~c_up;
  assign w_hold   = ~w_up & ~w_dn;
  assign w_cnt_en = ~w_ill & ~clr & ~ld;

  // Per-bit sum-of-products; a rotation, never an adder.
  for (genvar i = 0; i < N; i++) begin : g_bit
    localparam int   PRV = (i + N - 1) % N;
    localparam int   NXT = (i + 1) % N;
    localparam logic ZB  = (i == 0);

    assign w_hot[i] = (ld_val == W'(i));

    assign w_nxt[i] =
        (w_ill & ZB)
      | (~w_ill & clr & ZB)
      | (~w_ill & ~clr & ld & w_ok & w_hot[i])
      | (~w_ill & ~clr & ld & ~w_ok & r_st[i])
      | (w_cnt_en & w_up & r_st[PRV])
      | (w_cnt_en & w_dn & r_st[NXT])
      | (w_cnt_en & w_hold & r_st[i]);
  end

  assign w_wrap = w_cnt_en
                & ((w_up & r_st[N-1])
                 | (w_dn & r_st[0]));

  assign w_err = w_ill
               | (~clr & ld & ~w_ok);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_st   <= N'(1);
      r_wrap <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_st   <= w_nxt;
      r_wrap <= w_wrap;
      r_err  <= w_err;
    end
  end

  assign st   = r_st;
  assign cnt  = w_cnt;
  assign zero = r_st[0];
  assign wrap = r_wrap;
  assign err  = r_err;

endmodule

// File: tb/tb_onehot_updown_counter.sv
// Directed bench for onehot_updown_counter at N=6, 2, 16.
// Shared controls; each instance has its own load value.
module tb_onehot_updown_counter;

  logic clk;
  logic rst_b;
  logic clr;
  logic ld;
  logic c_up;
  logic c_dn;

  logic [2:0] ld_val6;
  logic [5:0] st6;
  logic [2:0] cnt6;
  logic       zero6;
  logic       wrap6;
  logic       err6;

  logic [0:0] ld_val2;
  logic [1:0] st2;
  logic [0:0] cnt2;
  logic       zero2;
  logic       wrap2;
  logic       err2;

  logic [3:0]  ld_val16;
  logic [15:0] st16;
  logic [3:0]  cnt16;
  logic        zero16;
  logic        wrap16;
  logic        err16;

  int n_cmp;
  int n_bad;

  onehot_updown_counter #(.N(6)) dut6 (
    .clk(clk), .rst_b(rst_b), .clr(clr), .ld(ld),
    .ld_val(ld_val6), .c_up(c_up), .c_dn(c_dn),
    .st(st6), .cnt(cnt6), .zero(zero6),
    .wrap(wrap6), .err(err6)
  );

  onehot_updown_counter #(.N(2)) dut2 (
    .clk(clk), .rst_b(rst_b), .clr(clr), .ld(ld),
    .ld_val(ld_val2), .c_up(c_up), .c_dn(c_dn),
    .st(st2), .cnt(cnt2), .zero(zero2),
    .wrap(wrap2), .err(err2)
  );

  onehot_updown_counter #(.N(16)) dut16 (
    .clk(clk), .rst_b(rst_b), .clr(clr), .ld(ld),
    .ld_val(ld_val16), .c_up(c_up), .c_dn(c_dn),
    .st(st16), .cnt(cnt16), .zero(zero16),
    .wrap(wrap16), .err(err16)
  );

  // Posedges at 10, 20, 30, ...
  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  task automatic idle();
    clr      = 1'b0;
    ld       = 1'b0;
    c_up     = 1'b0;
    c_dn     = 1'b0;
    ld_val6  = '0;
    ld_val2  = '0;
    ld_val16 = '0;
  endtask

  // Called 1 ns after an edge; pulses reset between edges.
  task automatic do_reset();
    idle();
    rst_b = 1'b0;
    #2;
    rst_b = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    rst_b = 1'b0;
    #3;
    n_cmp++;
    if (st6 !== 6'b000001 || cnt6 !== 3'd0 || zero6 !== 1'b1
        || wrap6 !== 1'b0 || err6 !== 1'b0) begin
      n_bad++;
      $display("FAIL reset6 got st=%b cnt=%0d z=%b w=%b e=%b want 000001 0 1 0 0",
               st6, cnt6, zero6, wrap6, err6);
    end
    n_cmp++;
    if (st2 !== 2'b01 || st16 !== 16'h0001
        || cnt16 !== 4'd0 || err16 !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_gen got st2=%b st16=%h cnt16=%0d want 01 0001 0",
               st2, st16, cnt16);
    end
    #22;
    rst_b = 1'b1;
  endtask

  task automatic test_up();
    int e;
    e = 0;
    c_up = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      @(posedge clk);
      #1;
      e = (e + 1) % 6;
      n_cmp++;
      if (cnt6 !== 3'(e) || st6 !== 6'(1 << e)
          || wrap6 !== (e == 0) || zero6 !== (e == 0)) begin
        n_bad++;
        $display("FAIL up k=%0d got cnt=%0d st=%b w=%b z=%b want cnt=%0d",
                 k, cnt6, st6, wrap6, zero6, e);
      end
    end
    c_up = 1'b0;
  endtask

  task automatic test_down();
    int e;
    int p;
    do_reset();
    e = 0;
    c_dn = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk);
      #1;
      p = e;
      e = (e + 5) % 6;
      n_cmp++;
      if (cnt6 !== 3'(e) || st6 !== 6'(1 << e)
          || wrap6 !== (p == 0) || err6 !== 1'b0) begin
        n_bad++;
        $display("FAIL down k=%0d got cnt=%0d w=%b want cnt=%0d w=%0d",
                 k, cnt6, wrap6, e, (p == 0));
      end
    end
    c_dn = 1'b0;
  endtask

  task automatic test_priority();
    do_reset();
    c_up = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (cnt6 !== 3'd3) begin
      n_bad++;
      $display("FAIL prio_pre got %0d want 3", cnt6);
    end
    clr     = 1'b1;
    ld      = 1'b1;
    ld_val6 = 3'd4;
    @(posedge clk);
    #1;
    n_cmp++;
    if (cnt6 !== 3'd0 || wrap6 !== 1'b0 || err6 !== 1'b0) begin
      n_bad++;
      $display("FAIL prio_clr got cnt=%0d w=%b e=%b want 0 0 0",
               cnt6, wrap6, err6);
    end
    clr = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if (cnt6 !== 3'd4 || wrap6 !== 1'b0) begin
      n_bad++;
      $display("FAIL prio_ld got cnt=%0d w=%b want 4 0", cnt6, wrap6);
    end
    ld   = 1'b0;
    c_dn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (cnt6 !== 3'd4 || wrap6 !== 1'b0 || err6 !== 1'b0) begin
      n_bad++;
      $display("FAIL prio_both got cnt=%0d w=%b want 4 0", cnt6, wrap6);
    end
    idle();
  endtask

  task automatic test_load();
    logic [2:0] bad_vals [2];
    bad_vals[0] = 3'd6;
    bad_vals[1] = 3'd7;
    ld      = 1'b1;
    ld_val6 = 3'd5;
    @(posedge clk);
    #1;
    n_cmp++;
    if (cnt6 !== 3'd5 || err6 !== 1'b0) begin
      n_bad++;
      $display("FAIL load5 got cnt=%0d e=%b want 5 0", cnt6, err6);
    end
    for (int j = 0; j < 2; j++) begin
      ld      = 1'b1;
      ld_val6 = bad_vals[j];
      @(posedge clk);
      #1;
      n_cmp++;
      if (cnt6 !== 3'd5 || err6 !== 1'b1 || wrap6 !== 1'b0) begin
        n_bad++;
        $display("FAIL load_bad v=%0d got cnt=%0d e=%b want 5 1",
                 bad_vals[j], cnt6, err6);
      end
      ld = 1'b0;
      @(posedge clk);
      #1;
      n_cmp++;
      if (cnt6 !== 3'd5 || err6 !== 1'b0) begin
        n_bad++;
        $display("FAIL load_err_clear got cnt=%0d e=%b want 5 0",
                 cnt6, err6);
      end
    end
    c_up = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (cnt6 !== 3'd0 || wrap6 !== 1'b1 || err6 !== 1'b0) begin
      n_bad++;
      $display("FAIL load_wrap got cnt=%0d w=%b want 0 1", cnt6, wrap6);
    end
    idle();
  endtask

  task automatic test_illegal();
    logic [5:0] pats [2];
    pats[0] = 6'b000110;
    pats[1] = 6'b000000;
    for (int j = 0; j < 2; j++) begin
      idle();
      c_up = (j == 0);
      force dut6.r_st = pats[j];
      #1;
      release dut6.r_st;
      @(posedge clk);
      #1;
      n_cmp++;
      if (st6 !== 6'b000001 || err6 !== 1'b1 || wrap6 !== 1'b0) begin
        n_bad++;
        $display("FAIL illegal p=%b got st=%b e=%b want 000001 1",
                 pats[j], st6, err6);
      end
      c_up = 1'b0;
      @(posedge clk);
      #1;
      n_cmp++;
      if (st6 !== 6'b000001 || err6 !== 1'b0) begin
        n_bad++;
        $display("FAIL illegal_after got st=%b e=%b want 000001 0",
                 st6, err6);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    c_up = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    n_cmp++;
    if (cnt6 !== 3'd4) begin
      n_bad++;
      $display("FAIL async_pre got %0d want 4", cnt6);
    end
    #2;
    rst_b = 1'b0;
    #1;
    n_cmp++;
    if (st6 !== 6'b000001 || cnt6 !== 3'd0 || zero6 !== 1'b1) begin
      n_bad++;
      $display("FAIL async_now got st=%b cnt=%0d want 000001 0",
               st6, cnt6);
    end
    #2;
    rst_b = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (cnt6 !== 3'd1 || wrap6 !== 1'b0) begin
      n_bad++;
      $display("FAIL async_resume got cnt=%0d want 1", cnt6);
    end
    idle();
  endtask

  task automatic test_generic(input int n);
    int e;
    int p;
    int oc;
    logic ow;
    logic oz;
    for (int dir = 0; dir < 2; dir++) begin
      do_reset();
      c_up = (dir == 0);
      c_dn = (dir == 1);
      e = 0;
      for (int k = 1; k <= 2 * n; k++) begin
        @(posedge clk);
        #1;
        p = e;
        e = (dir == 0) ? (e + 1) % n : (e + n - 1) % n;
        if (n == 2) begin
          oc = int'(cnt2);
          ow = wrap2;
          oz = zero2;
        end else begin
          oc = int'(cnt16);
          ow = wrap16;
          oz = zero16;
        end
        n_cmp++;
        if (oc !== e || oz !== (e == 0)
            || ow !== ((dir == 0) ? (e == 0) : (p == 0))) begin
          n_bad++;
          $display("FAIL gen N=%0d dir=%0d k=%0d got cnt=%0d w=%b want cnt=%0d",
                   n, dir, k, oc, ow, e);
        end
      end
    end
    idle();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_up();
    test_down();
    test_priority();
    test_load();
    test_illegal();
    test_async_reset();
    test_generic(2);
    test_generic(16);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
